// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 capture path.
package hub75_pkg;

  typedef logic [8:0] pixel_t;
  typedef pixel_t [1:0] pixel_pair_t;

  localparam int R_OFS = 0;
  localparam int G_OFS = 3;
  localparam int B_OFS = 6;

  function automatic int addr_width(input int scan_rate);
    return (scan_rate > 1) ? $clog2(scan_rate) : 1;
  endfunction

endpackage

// File: rtl/hub75_in_sync.sv
// Multi-stage synchroniser for the whole HUB75 input bus, with rising-edge
// detection on the shift clock and latch lines.
module hub75_in_sync #(
  parameter int DATA_W = 1,
  parameter int STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              hub_clk_in,
  input  logic              hub_latch_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              clk_rise_out,
  output logic              latch_rise_out
);

  localparam int W = DATA_W + 2;

  logic [W-1:0] chain [STAGES];
  logic [1:0]   edge_prev_reg;
  logic [W-1:0] sync_last;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [W-1:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_in or posedge rst_in) begin
          if (rst_in) q_reg <= '0;
          else        q_reg <= {hub_latch_in, hub_clk_in, data_in};
        end
      end else begin : g_next
        always_ff @(posedge clk_in or posedge rst_in) begin
          if (rst_in) q_reg <= '0;
          else        q_reg <= chain[gi-1];
        end
      end
      assign chain[gi] = q_reg;
    end
  endgenerate

  assign sync_last = chain[STAGES-1];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) edge_prev_reg <= '0;
    else        edge_prev_reg <= sync_last[W-1:W-2];
  end

  assign data_out       = sync_last[DATA_W-1:0];
  assign clk_rise_out   = sync_last[DATA_W]   & ~edge_prev_reg[0];
  assign latch_rise_out = sync_last[DATA_W+1] & ~edge_prev_reg[1];

endmodule

// File: rtl/hub75_capture.sv
// HUB75 panel emulator: rebuilds BCM rows from the panel bus and streams pixel pairs.
// Optional HUB75_CAPTURE_BCM_CHECK_EN adds per-plane OE on-time measurement and checking.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int NUM_COLS    = 64,
  parameter int SCAN_RATE   = 32,
  parameter int BCM_BITS    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = addr_width(SCAN_RATE),
  parameter int COL_W       = $clog2(NUM_COLS)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              hub_clk_in,
  input  logic              hub_latch_in,
  input  logic              hub_oe_in,
  input  logic [ADDR_W-1:0] hub_addr_in,
  input  logic [2:0]        hub_rgb0_in,
  input  logic [2:0]        hub_rgb1_in,
  output logic              pix_valid_out,
  input  logic              pix_ready_in,
  output pixel_pair_t       pix_data_out,
  output logic [COL_W-1:0]  pix_col_out,
  output logic [ADDR_W-1:0] pix_row_out,
  output logic              len_err_out,
  output logic              overrun_out
`ifdef HUB75_CAPTURE_BCM_CHECK_EN
  ,
  output logic              bcm_err_out,
  output logic [15:0]       plane_on_cycles_out
`endif
);

  localparam int PLANE_W = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1;
  localparam logic [COL_W:0]     FULL_CNT   = (COL_W+1)'(NUM_COLS);
  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(NUM_COLS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BCM_BITS - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  logic              s_oe, clk_rise, latch_rise;
  logic [ADDR_W-1:0] s_addr;
  logic [2:0]        s_rgb0, s_rgb1;

  hub75_in_sync #(.DATA_W(7 + ADDR_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hub_clk_in    (hub_clk_in),
    .hub_latch_in  (hub_latch_in),
    .data_in       ({hub_oe_in, hub_addr_in, hub_rgb1_in, hub_rgb0_in}),
    .data_out      ({s_oe, s_addr, s_rgb1, s_rgb0}),
    .clk_rise_out  (clk_rise),
    .latch_rise_out(latch_rise)
  );

  state_t             state_reg;
  logic [COL_W:0]     shift_cnt_reg, cnt_eff;
  logic [PLANE_W-1:0] plane_reg, plane_eff;
  logic [ADDR_W-1:0]  last_addr_reg, row_reg;
  logic [COL_W-1:0]   col_reg, col_next;
  logic               valid_reg, len_err_reg, overrun_reg;
  pixel_pair_t        data_reg;
  pixel_pair_t        acc_col [NUM_COLS];
  logic               acc_we, acc_clr;
  logic [3:0]         bit_r, bit_g, bit_b;

  // A shift edge coinciding with the latch edge is counted into the commit.
  assign cnt_eff   = (clk_rise && shift_cnt_reg != FULL_CNT) ? shift_cnt_reg + 1'b1 : shift_cnt_reg;
  assign plane_eff = (s_addr != last_addr_reg) ? '0 : plane_reg;
  assign acc_we    = latch_rise && (state_reg == COLLECT);
  assign acc_clr   = (state_reg == DRAIN) && valid_reg && pix_ready_in && (col_reg == LAST_COL);
  assign col_next  = col_reg + 1'b1;
  assign bit_r     = 4'(R_OFS) + 4'(plane_eff);
  assign bit_g     = 4'(G_OFS) + 4'(plane_eff);
  assign bit_b     = 4'(B_OFS) + 4'(plane_eff);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
      logic [5:0]  shift_bits_reg;
      logic [5:0]  cap;
      logic        hit;
      pixel_pair_t acc_reg;

      assign hit = clk_rise && (shift_cnt_reg == (COL_W+1)'(gi));
      // Columns never shifted this plane commit as zero, not stale data.
      assign cap = (cnt_eff > (COL_W+1)'(gi)) ? (hit ? {s_rgb1, s_rgb0} : shift_bits_reg) : 6'd0;

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          shift_bits_reg <= '0;
          acc_reg        <= '0;
        end else begin
          if (hit) shift_bits_reg <= {s_rgb1, s_rgb0};
          if (acc_we) begin
            acc_reg[0][bit_r] <= cap[0];
            acc_reg[0][bit_g] <= cap[1];
            acc_reg[0][bit_b] <= cap[2];
            acc_reg[1][bit_r] <= cap[3];
            acc_reg[1][bit_g] <= cap[4];
            acc_reg[1][bit_b] <= cap[5];
          end else if (acc_clr) begin
            acc_reg <= '0;
          end
        end
      end

      assign acc_col[gi] = acc_reg;
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= COLLECT;
      shift_cnt_reg <= '0;
      plane_reg     <= '0;
      last_addr_reg <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      valid_reg     <= 1'b0;
      data_reg      <= '0;
      len_err_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (clk_rise && shift_cnt_reg != FULL_CNT) shift_cnt_reg <= shift_cnt_reg + 1'b1;
      if (latch_rise) begin
        shift_cnt_reg <= '0;
        last_addr_reg <= s_addr;
        if (cnt_eff != FULL_CNT)  len_err_reg <= 1'b1;
        if (state_reg == DRAIN)   overrun_reg <= 1'b1;
        if (plane_eff == LAST_PLANE) begin
          plane_reg <= '0;
          if (state_reg == COLLECT) begin
            row_reg   <= s_addr;
            col_reg   <= '0;
            state_reg <= DRAIN;
          end
        end else begin
          plane_reg <= plane_eff + 1'b1;
        end
      end
      if (state_reg == DRAIN) begin
        if (!valid_reg) begin
          valid_reg <= 1'b1;
          data_reg  <= acc_col[col_reg];
        end else if (pix_ready_in) begin
          if (col_reg == LAST_COL) begin
            valid_reg <= 1'b0;
            state_reg <= COLLECT;
          end else begin
            col_reg  <= col_next;
            data_reg <= acc_col[col_next];
          end
        end
      end
    end
  end

  assign pix_valid_out = valid_reg;
  assign pix_data_out  = data_reg;
  assign pix_col_out   = col_reg;
  assign pix_row_out   = row_reg;
  assign len_err_out   = len_err_reg;
  assign overrun_out   = overrun_reg;

`ifdef HUB75_CAPTURE_BCM_CHECK_EN
  logic [15:0] on_cnt_reg, on_meas, prev_on_reg, plane_on_reg;
  logic        bcm_err_reg;

  // The commit cycle's own OE sample belongs to the plane being committed.
  assign on_meas = (!s_oe && on_cnt_reg != 16'hFFFF) ? on_cnt_reg + 16'd1 : on_cnt_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      on_cnt_reg   <= '0;
      prev_on_reg  <= '0;
      plane_on_reg <= '0;
      bcm_err_reg  <= 1'b0;
    end else if (latch_rise) begin
      on_cnt_reg   <= '0;
      prev_on_reg  <= on_meas;
      plane_on_reg <= on_meas;
      if (plane_eff != '0 && {1'b0, on_meas} < {prev_on_reg, 1'b0}) bcm_err_reg <= 1'b1;
    end else begin
      on_cnt_reg <= on_meas;
    end
  end

  assign bcm_err_out         = bcm_err_reg;
  assign plane_on_cycles_out = plane_on_reg;
`else
  logic oe_unused;
  assign oe_unused = s_oe;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Self-checking bench for hub75_capture: random bit-planes against a pixel model.
`timescale 1ns/1ps
module tb_hub75_capture;
  import hub75_pkg::*;

  localparam int NUM_COLS    = 64;
  localparam int ADDR_W      = 5;
  localparam int COL_W       = 6;
  localparam int SYNC_STAGES = 2;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              hub_clk_in = 1'b0;
  logic              hub_latch_in = 1'b0;
  logic              hub_oe_in = 1'b1;
  logic [ADDR_W-1:0] hub_addr_in = '0;
  logic [2:0]        hub_rgb0_in = '0;
  logic [2:0]        hub_rgb1_in = '0;
  logic              pix_valid_out;
  logic              pix_ready_in = 1'b0;
  pixel_pair_t       pix_data_out;
  logic [COL_W-1:0]  pix_col_out;
  logic [ADDR_W-1:0] pix_row_out;
  logic              len_err_out;
  logic              overrun_out;
`ifdef HUB75_CAPTURE_BCM_CHECK_EN
  logic              bcm_err_out;
  logic [15:0]       plane_on_cycles_out;
`endif

  int errors = 0;
  int checks = 0;

  logic [2:0]  r0_q [NUM_COLS];
  logic [2:0]  r1_q [NUM_COLS];
  pixel_pair_t exp_pix [NUM_COLS];

  hub75_capture dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hub_clk_in    (hub_clk_in),
    .hub_latch_in  (hub_latch_in),
    .hub_oe_in     (hub_oe_in),
    .hub_addr_in   (hub_addr_in),
    .hub_rgb0_in   (hub_rgb0_in),
    .hub_rgb1_in   (hub_rgb1_in),
    .pix_valid_out (pix_valid_out),
    .pix_ready_in  (pix_ready_in),
    .pix_data_out  (pix_data_out),
    .pix_col_out   (pix_col_out),
    .pix_row_out   (pix_row_out),
    .len_err_out   (len_err_out),
    .overrun_out   (overrun_out)
`ifdef HUB75_CAPTURE_BCM_CHECK_EN
    ,
    .bcm_err_out        (bcm_err_out),
    .plane_on_cycles_out(plane_on_cycles_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM_COLS; i++) begin
      r0_q[i] = 3'($urandom);
      r1_q[i] = 3'($urandom);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_COLS; i++) exp_pix[i] = '0;
  endtask

  // Pixel bit (3*channel + plane) holds that channel's bit from the given plane.
  task automatic model_plane(input int p, input int n);
    pixel_t mask;
    for (int col = 0; col < NUM_COLS; col++) begin
      for (int c = 0; c < 3; c++) begin
        mask = 9'd1 << (c * 3 + p);
        exp_pix[col][0] = exp_pix[col][0] & ~mask;
        exp_pix[col][1] = exp_pix[col][1] & ~mask;
        if (col < n && ((r0_q[col] >> c) & 3'd1) != 3'd0) exp_pix[col][0] = exp_pix[col][0] | mask;
        if (col < n && ((r1_q[col] >> c) & 3'd1) != 3'd0) exp_pix[col][1] = exp_pix[col][1] | mask;
      end
    end
  endtask

  task automatic shift_plane(input int n);
    for (int i = 0; i < n; i++) begin
      hub_rgb0_in = r0_q[i % NUM_COLS];
      hub_rgb1_in = r1_q[i % NUM_COLS];
      hub_clk_in  = 1'b0;
      tick(2);
      hub_clk_in  = 1'b1;
      tick(2);
    end
    hub_clk_in = 1'b0;
    tick(2);
  endtask

  task automatic pulse_latch(input int addr);
    hub_addr_in  = ADDR_W'(addr);
    tick(1);
    hub_latch_in = 1'b1;
    tick(3);
    hub_latch_in = 1'b0;
    tick(3);
  endtask

  task automatic send_plane(input int addr, input int p, input int n);
    shift_plane(n);
    model_plane(p, n);
    pulse_latch(addr);
  endtask

  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (!pix_valid_out && cyc < 50) begin
      tick(1);
      cyc++;
    end
    checks++;
    if (pix_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_valid: valid=%b after %0d cycles, required 1", tag, pix_valid_out, cyc);
    end
  endtask

  // mode 0: ready always high, 1: toggling, 2: random
  task automatic drain_check(input int row, input int mode, input string tag);
    int          beats = 0;
    int          cyc = 0;
    logic        stall = 1'b0;
    logic        rdy;
    pixel_pair_t dp = '0;
    logic [COL_W-1:0] cp = '0;
    while (beats < NUM_COLS && cyc < 4000) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (stall) begin
        checks++;
        if (pix_valid_out !== 1'b1 || pix_data_out !== dp || pix_col_out !== cp) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b col=%0d data=%h_%h, required valid=1 col=%0d data=%h_%h",
                   tag, pix_valid_out, pix_col_out, pix_data_out[1], pix_data_out[0], cp, dp[1], dp[0]);
        end
      end
      pix_ready_in = rdy;
      if (pix_valid_out && rdy) begin
        checks++;
        if (pix_col_out !== COL_W'(beats) || pix_row_out !== ADDR_W'(row) || pix_data_out !== exp_pix[beats]) begin
          errors++;
          $display("FAIL %s beat%0d: row=%0d col=%0d data=%h_%h, required row=%0d col=%0d data=%h_%h",
                   tag, beats, pix_row_out, pix_col_out, pix_data_out[1], pix_data_out[0],
                   row, beats, exp_pix[beats][1], exp_pix[beats][0]);
        end
        beats++;
      end
      stall = pix_valid_out && !rdy;
      dp    = pix_data_out;
      cp    = pix_col_out;
      tick(1);
      cyc++;
    end
    pix_ready_in = 1'b0;
    checks++;
    if (beats != NUM_COLS) begin
      errors++;
      $display("FAIL %s beat_count: got %0d beats, required %0d", tag, beats, NUM_COLS);
    end
    checks++;
    if (pix_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_after_last: valid=%b, required 0", tag, pix_valid_out);
    end
    tick(2);
  endtask

  task automatic check_flags(input string tag, input logic len_exp, input logic ovr_exp);
    checks++;
    if (len_err_out !== len_exp || overrun_out !== ovr_exp) begin
      errors++;
      $display("FAIL %s flags: len_err=%b overrun=%b, required len_err=%b overrun=%b",
               tag, len_err_out, overrun_out, len_exp, ovr_exp);
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if (pix_valid_out !== 1'b0 || pix_data_out !== '0 || pix_col_out !== '0 || pix_row_out !== '0 ||
        len_err_out !== 1'b0 || overrun_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h_%h col=%0d row=%0d len=%b ovr=%b, required all 0",
               pix_valid_out, pix_data_out[1], pix_data_out[0], pix_col_out, pix_row_out, len_err_out, overrun_out);
    end
    rst_in = 1'b0;
    tick(3);
    checks++;
    if (pix_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_valid: valid=%b, required 0", pix_valid_out);
    end
  endtask

  task automatic test_basic();
    int lat = 0;
    for (int i = 0; i < NUM_COLS; i++) begin
      r0_q[i] = 3'b001;
      r1_q[i] = 3'b100;
    end
    model_clear();
    send_plane(5, 0, NUM_COLS);
    send_plane(5, 1, NUM_COLS);
    shift_plane(NUM_COLS);
    model_plane(2, NUM_COLS);
    hub_addr_in = ADDR_W'(5);
    tick(1);
    hub_latch_in = 1'b1;
    while (!pix_valid_out && lat < 20) begin
      tick(1);
      lat++;
    end
    checks++;
    if (lat != SYNC_STAGES + 2) begin
      errors++;
      $display("FAIL basic_latency: first valid %0d cycles after latch pin, required %0d", lat, SYNC_STAGES + 2);
    end
    hub_latch_in = 1'b0;
    tick(3);
    drain_check(5, 0, "basic");
    check_flags("basic", 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    int row = $urandom_range(0, 31);
    model_clear();
    for (int p = 0; p < 3; p++) begin
      fill_random();
      send_plane(row, p, NUM_COLS);
    end
    drain_check(row, 1, "stall");
    check_flags("stall", 1'b0, 1'b0);
  endtask

  task automatic test_len_err();
    int row = $urandom_range(0, 31);
    model_clear();
    fill_random();
    send_plane(row, 0, NUM_COLS);
    fill_random();
    send_plane(row, 1, 60);
    check_flags("len_err", 1'b1, 1'b0);
    fill_random();
    send_plane(row, 2, NUM_COLS);
    drain_check(row, 2, "len_err");
  endtask

  task automatic test_overrun();
    model_clear();
    for (int p = 0; p < 3; p++) begin
      fill_random();
      send_plane(3, p, NUM_COLS);
    end
    wait_valid("overrun");
    fill_random();
    shift_plane(NUM_COLS);
    pulse_latch(9);
    check_flags("overrun", 1'b1, 1'b1);
    checks++;
    if (pix_valid_out !== 1'b1 || pix_col_out !== '0) begin
      errors++;
      $display("FAIL overrun_hold: valid=%b col=%0d, required valid=1 col=0", pix_valid_out, pix_col_out);
    end
    drain_check(3, 2, "overrun");
  endtask

  task automatic test_addr_change();
    fill_random();
    shift_plane(NUM_COLS);
    pulse_latch(2);
    model_clear();
    for (int p = 0; p < 3; p++) begin
      fill_random();
      send_plane(7, p, NUM_COLS);
      if (p < 2) begin
        checks++;
        if (pix_valid_out !== 1'b0) begin
          errors++;
          $display("FAIL addr_change_early_drain: valid=%b after row7 plane %0d, required 0", pix_valid_out, p);
        end
      end
    end
    drain_check(7, 0, "addr_change");
  endtask

`ifdef HUB75_CAPTURE_BCM_CHECK_EN
  task automatic send_plane_oe(input int addr, input int p, input int on);
    fill_random();
    shift_plane(NUM_COLS);
    model_plane(p, NUM_COLS);
    hub_oe_in = 1'b0;
    tick(on);
    hub_oe_in = 1'b1;
    tick(1);
    pulse_latch(addr);
  endtask

  task automatic test_bcm();
    int row = $urandom_range(0, 31);
    model_clear();
    send_plane_oe(row, 0, 10);
    send_plane_oe(row, 1, 20);
    send_plane_oe(row, 2, 40);
    checks++;
    if (bcm_err_out !== 1'b0 || plane_on_cycles_out !== 16'd40) begin
      errors++;
      $display("FAIL bcm_good: bcm_err=%b on=%0d, required bcm_err=0 on=40", bcm_err_out, plane_on_cycles_out);
    end
    drain_check(row, 0, "bcm_good");
    model_clear();
    send_plane_oe(row, 0, 10);
    send_plane_oe(row, 1, 15);
    checks++;
    if (bcm_err_out !== 1'b1 || plane_on_cycles_out !== 16'd15) begin
      errors++;
      $display("FAIL bcm_short: bcm_err=%b on=%0d, required bcm_err=1 on=15", bcm_err_out, plane_on_cycles_out);
    end
    send_plane_oe(row, 2, 40);
    drain_check(row, 0, "bcm_short");
  endtask
`endif

  task automatic test_reset_mid_drain();
    model_clear();
    for (int p = 0; p < 3; p++) begin
      fill_random();
      send_plane(11, p, NUM_COLS);
    end
    wait_valid("reset_mid_drain");
    pix_ready_in = 1'b1;
    tick(5);
    pix_ready_in = 1'b0;
    rst_in = 1'b1;
    #1;
    checks++;
    if (pix_valid_out !== 1'b0 || len_err_out !== 1'b0 || overrun_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drain: valid=%b len=%b ovr=%b, required all 0", pix_valid_out, len_err_out, overrun_out);
    end
`ifdef HUB75_CAPTURE_BCM_CHECK_EN
    checks++;
    if (bcm_err_out !== 1'b0 || plane_on_cycles_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_drain_bcm: bcm_err=%b on=%0d, required 0", bcm_err_out, plane_on_cycles_out);
    end
`endif
    tick(2);
    rst_in = 1'b0;
    tick(4);
    checks++;
    if (pix_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_row_lost: valid=%b, required 0", pix_valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len_err();
    test_overrun();
    test_addr_change();
`ifdef HUB75_CAPTURE_BCM_CHECK_EN
    test_bcm();
`endif
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- HUB75 receiver / panel emulator: samples the panel-side bus produced by the team's HUB75 driver (rgb0/rgb1, led_clk, latch, OE, row address).
- Rebuilds each row's 9-bit pixels from the 3 BCM bit-planes and streams them out over valid/ready.
- Used as a loopback checker on the FPGA and as the scoreboard front-end in driver benches.
- Runs on a system clock at least 4x faster than the HUB75 shift clock.

Parameters:
- NUM_COLS, 64, pixels shifted per line per channel.
- SCAN_RATE, 32, number of row addresses; ADDR_W = $clog2(SCAN_RATE).
- BCM_BITS, 3, bit-planes per colour channel.
- SYNC_STAGES, 2, synchroniser depth on all HUB75 inputs.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- hub_clk_in  in  1  HUB75 shift clock (async).
- hub_latch_in  in  1  HUB75 latch, active-high.
- hub_oe_in  in  1  HUB75 output enable, active-low (1 = blanked).
- hub_addr_in  in  ADDR_W  row address.
- hub_rgb0_in  in  3  upper-half bits {B,G,R}, bit 0 = R.
- hub_rgb1_in  in  3  lower-half bits.
- pix_valid_out  out  1  pixel pair valid.
- pix_ready_in  in  1  downstream ready.
- pix_data_out  out  2x9  [h][8:0]; R=[2:0], G=[5:3], B=[8:6]; h=0 upper, h=1 lower.
- pix_col_out  out  $clog2(NUM_COLS)  column of the current pair.
- pix_row_out  out  ADDR_W  row address of the current pair.
- len_err_out  out  1  sticky: latch seen with shift count != NUM_COLS.
- overrun_out  out  1  sticky: plane committed while draining.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state COLLECT; shift count 0; plane 0; accumulator cleared.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised hub_clk and hub_latch.
- Shift: on each hub_clk rising edge, capture synchronised rgb0/rgb1 into a NUM_COLS-deep shift register. The first bit shifted lands at column 0. Shift count saturates at NUM_COLS.
- Latch rising edge (commit):
  - If shift count != NUM_COLS, set len_err_out and commit anyway. Missing columns read as 0; excess columns are dropped.
  - If hub_addr differs from the address of the previous commit, plane resets to 0.
  - Write shift-register bit for channel c into accumulator bit [c*3 + plane] for every column.
  - plane += 1 and shift count := 0.
- When plane BCM_BITS-1 is committed: latch the row address, plane := 0, and go to DRAIN the following cycle.
- DRAIN:
  - Present column 0..NUM_COLS-1 in order. Advance on pix_valid_out & pix_ready_in.
  - Data, col and row are held stable while valid is high and ready is low.
  - After column NUM_COLS-1 is accepted: valid drops the next cycle, accumulator clears, return to COLLECT.
- Shifting continues during DRAIN; the shift register is independent of the accumulator.
- A latch during DRAIN sets overrun_out and the plane is discarded. Plane count and address tracking still update.
- Simultaneous hub_clk edge and latch edge in one cycle: the shift happens first and is included in the commit.
- First valid pair appears 1 cycle after the final-plane commit; that commit is SYNC_STAGES+1 cycles after the pin edge.
- Sticky flags clear only on reset.
- Reset mid-DRAIN: valid drops immediately (async) and the partial row is lost.

Optional Feature:
- Macro: HUB75_CAPTURE_BCM_CHECK_EN.
- Defined:
  - Counts clk_in cycles with synchronised hub_oe low between consecutive commits (per plane).
  - Adds output bcm_err_out (1 bit, sticky). Set if plane p's on-time (p>0) is < 2x plane p-1's on-time within the same row.
  - Adds output plane_on_cycles_out (16 bits, saturating): last measured on-time.
- Undefined: neither port exists, no counters are built, behaviour otherwise identical.

Decomposition:
- Package hub75_pkg holds:
  - typedef pixel_t (9-bit) and typedef pixel_pair_t ([1:0] pixel_t);
  - localparams R_OFS=0, G_OFS=3, B_OFS=6;
  - function addr_width(scan_rate).
- One sub-module, hub75_in_sync: parameterised multi-bit synchroniser plus rising-edge detect for clk/latch. Instantiated once for the whole input bus.

Test Plan:
1. Row addr 5, three planes, each 64 clocks + latch, all rgb0=3'b001 and rgb1=3'b100 on every plane → 64 pairs, pix_row_out=5, cols 0..63, data[0]=9'h007, data[1]=9'h1C0, no flags.
2. Same as 1 but ready toggles 1/0 every cycle → exactly 64 beats, data stable during stalls, valid low after beat 63.
3. Plane 1 shifted with only 60 clocks → len_err_out=1; cols 60..63 have bit 1 of each channel = 0.
4. Second row's first latch issued while row 3 is mid-drain with ready held 0 → overrun_out=1; row 3 output is unchanged when ready resumes.
5. Address changes 2→7 after one plane → plane resets; row 7 drains after its 3rd latch with pix_row_out=7.
6. BCM_CHECK_EN: OE-low times 10/20/40 cycles → bcm_err_out=0; times 10/15/40 → bcm_err_out=1. Assert rst_in mid-drain → valid=0 same cycle, all flags 0.
